// File: rtl/fb_pixel_reader.sv
// Custom-instruction slave that reads up to MAX_PIX consecutive pixels from the
// 1-bit frame RAM over an arbitrated read port and returns them packed in result.
module fb_pixel_reader #(
  parameter int ADDR_W  = 12,
  parameter int MAX_PIX = 32,
  parameter int RAM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        dataa,
  input  logic [31:0]        datab,
  output logic [MAX_PIX-1:0] result,
  output logic               done,
  output logic               rd_req,
  input  logic               rd_grant,
  output logic [ADDR_W-1:0]  rdaddress,
  input  logic               q
);

  localparam int CNT_W = $clog2(MAX_PIX + 1);
  localparam int TAG_W = $clog2(MAX_PIX);

  typedef enum logic [2:0] {IDLE, REQ, BURST, DRAIN, FINISH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_pix;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   cap_cnt;
  logic [MAX_PIX-1:0] shadow;
  logic               vld_p [RAM_LAT];
  logic [TAG_W-1:0]   tag_p [RAM_LAT];
  logic               issue;
  logic               capture;
  logic               unused_bits;

  // A count of zero or anything beyond MAX_PIX saturates to a full-width read.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] raw);
    if (raw == '0 || raw > CNT_W'(MAX_PIX))
      return CNT_W'(MAX_PIX);
    return raw;
  endfunction

  assign unused_bits = ^{dataa[31:ADDR_W], datab[31:CNT_W]};
  assign issue       = (state == REQ || state == BURST) && rd_grant;
  assign capture     = vld_p[RAM_LAT-1];

  // Stage p0..p(RAM_LAT-1): valid/tag travel alongside the RAM read latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < RAM_LAT; k++)
        vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int k = 1; k < RAM_LAT; k++)
        vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= issue_cnt[TAG_W-1:0];
    for (int k = 1; k < RAM_LAT; k++)
      tag_p[k] <= tag_p[k-1];
  end

  // Capture stage: q lines up with the last pipe entry
  always_ff @(posedge clk) begin
    if (state == IDLE && start)
      shadow <= '0;
    else if (capture)
      shadow[tag_p[RAM_LAT-1]] <= q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      result    <= '0;
      done      <= 1'b0;
      rd_req    <= 1'b0;
      rdaddress <= '0;
      n_pix     <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (capture)
        cap_cnt <= cap_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            n_pix     <= sat_count(datab[CNT_W-1:0]);
            rdaddress <= dataa[ADDR_W-1:0];
            issue_cnt <= '0;
            cap_cnt   <= '0;
            rd_req    <= 1'b1;
            state     <= REQ;
          end
        end
        REQ, BURST: begin
          if (rd_grant) begin
            rdaddress <= rdaddress + ADDR_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
            state     <= BURST;
            if (issue_cnt + CNT_W'(1) == n_pix) begin
              rd_req <= 1'b0;
              state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cap_cnt == n_pix) begin
            result <= shadow;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Bench for fb_pixel_reader: behavioural frame RAM plus a pixel-level reference model.
module tb_fb_pixel_reader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic [31:0]       result;
  logic              done;
  logic              rd_req;
  logic              rd_grant;
  logic [ADDR_W-1:0] rdaddress;
  logic              q;

  bit                mem [DEPTH];
  logic [ADDR_W-1:0] issued [$];
  int                total = 0;
  int                bad   = 0;

  fb_pixel_reader #(.ADDR_W(ADDR_W), .MAX_PIX(32), .RAM_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .result    (result),
    .done      (done),
    .rd_req    (rd_req),
    .rd_grant  (rd_grant),
    .rdaddress (rdaddress),
    .q         (q)
  );

  always #5 clk = ~clk;

  // One-cycle-latency frame RAM
  always @(posedge clk) q <= mem[rdaddress];

  function automatic int model_count(input logic [31:0] raw);
    int r;
    r = int'(raw & 32'd63);
    return (r == 0 || r > 32) ? 32 : r;
  endfunction

  function automatic logic [31:0] model_result(input int base, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      r[k] = mem[(base + k) & (DEPTH - 1)];
    return r;
  endfunction

  function automatic int seq_errors(input int base, input int n);
    int e;
    e = 0;
    if (issued.size() != n) e++;
    for (int k = 0; k < n && k < issued.size(); k++)
      if (issued[k] !== ADDR_W'((base + k) & (DEPTH - 1))) e++;
    return e;
  endfunction

  task automatic do_read(input int base, input logic [31:0] cnt_raw, input bit throttle,
                         input int restart_at, output logic [31:0] res, output int lat,
                         output int pulses, output logic req_after);
    issued.delete();
    res = '0; lat = -1; pulses = 0;
    @(negedge clk);
    dataa = {20'($urandom), 12'(base)};
    datab = cnt_raw;
    start = 1'b1;
    rd_grant = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == restart_at) begin
        start = 1'b1;
        dataa = $urandom;
        datab = 32'd32;
      end
      rd_grant = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rd_req && rd_grant) issued.push_back(rdaddress);
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          res = result;
        end
      end
      if (lat >= 0 && c >= lat + 3) break;
    end
    start = 1'b0;
    rd_grant = 1'b1;
    req_after = rd_req;
  endtask

  task automatic test_reset();
    int dcount;
    int rcount;
    dcount = 0; rcount = 0;
    reset = 1'b0; start = 1'b0; dataa = '0; datab = '0; rd_grant = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b want=0", rd_req); end
    total++; if (rdaddress !== '0) begin bad++; $display("FAIL reset_rdaddress got=%0d want=0", rdaddress); end
    repeat (50) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (rd_req) rcount++;
    end
    total++; if (dcount !== 0) begin bad++; $display("FAIL idle_no_done got=%0d want=0", dcount); end
    total++; if (rcount !== 0) begin bad++; $display("FAIL idle_no_req got=%0d want=0", rcount); end
  endtask

  task automatic test_full_burst();
    logic [31:0] res; int lat; int pulses; logic req_after;
    for (int k = 0; k < DEPTH; k++) mem[k] = k[0];
    do_read(0, 32'd32, 1'b0, 0, res, lat, pulses, req_after);
    total++; if (res !== 32'hAAAAAAAA) begin bad++; $display("FAIL full_result got=%h want=aaaaaaaa", res); end
    total++; if (res !== model_result(0, 32)) begin bad++; $display("FAIL full_model got=%h want=%h", res, model_result(0, 32)); end
    total++; if (lat !== 34) begin bad++; $display("FAIL full_latency got=%0d want=34", lat); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL full_done_width got=%0d want=1", pulses); end
    total++; if (seq_errors(0, 32) !== 0) begin bad++; $display("FAIL full_issue_seq errs=%0d want=0", seq_errors(0, 32)); end
  endtask

  task automatic test_wrap();
    logic [31:0] res; int lat; int pulses; logic req_after;
    for (int k = 0; k < DEPTH; k++) mem[k] = 1'b0;
    mem[4094] = 1'b1; mem[4095] = 1'b1; mem[0] = 1'b1;
    do_read(4093, 32'd5, 1'b0, 0, res, lat, pulses, req_after);
    total++; if (res !== 32'h0000000E) begin bad++; $display("FAIL wrap_result got=%h want=0000000e", res); end
    total++; if (seq_errors(4093, 5) !== 0) begin bad++; $display("FAIL wrap_issue_seq errs=%0d want=0", seq_errors(4093, 5)); end
    total++; if (lat !== 7) begin bad++; $display("FAIL wrap_latency got=%0d want=7", lat); end
  endtask

  task automatic test_throttle();
    logic [31:0] res; int lat; int pulses; logic req_after; int base; int n;
    foreach (mem[i]) mem[i] = 1'($urandom_range(0, 1));
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      n = (it == 0) ? 32 : $urandom_range(1, 32);
      do_read(base, 32'(n), 1'b1, 0, res, lat, pulses, req_after);
      total++; if (res !== model_result(base, n)) begin bad++; $display("FAIL thr_result it=%0d got=%h want=%h", it, res, model_result(base, n)); end
      total++; if (seq_errors(base, n) !== 0) begin bad++; $display("FAIL thr_issue_once it=%0d errs=%0d want=0", it, seq_errors(base, n)); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL thr_done it=%0d got=%0d want=1", it, pulses); end
    end
  endtask

  task automatic test_count_encoding();
    logic [31:0] raws [6];
    logic [31:0] res; int lat; int pulses; logic req_after; int base; int n;
    raws = '{32'd0, 32'd45, 32'd1, 32'd33, 32'd32, 32'hFFFF_FF07};
    foreach (mem[i]) mem[i] = 1'b1;
    foreach (raws[r]) begin
      base = $urandom_range(0, DEPTH - 1);
      n = model_count(raws[r]);
      do_read(base, raws[r], 1'b0, 0, res, lat, pulses, req_after);
      total++; if (res !== model_result(base, n)) begin bad++; $display("FAIL cnt_result raw=%0d got=%h want=%h", raws[r], res, model_result(base, n)); end
      total++; if (lat !== n + 2) begin bad++; $display("FAIL cnt_latency raw=%0d got=%0d want=%0d", raws[r], lat, n + 2); end
    end
  endtask

  task automatic test_busy();
    logic [31:0] res; int lat; int pulses; logic req_after; int base;
    foreach (mem[i]) mem[i] = 1'($urandom_range(0, 1));
    base = $urandom_range(0, DEPTH - 1);
    do_read(base, 32'd32, 1'b0, 10, res, lat, pulses, req_after);
    total++; if (res !== model_result(base, 32)) begin bad++; $display("FAIL busy_result got=%h want=%h", res, model_result(base, 32)); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_done_once got=%0d want=1", pulses); end
    total++; if (seq_errors(base, 32) !== 0) begin bad++; $display("FAIL busy_issue_seq errs=%0d want=0", seq_errors(base, 32)); end
    base = $urandom_range(0, DEPTH - 1);
    do_read(base, 32'd32, 1'b0, 35, res, lat, pulses, req_after);
    total++; if (req_after !== 1'b0) begin bad++; $display("FAIL finish_start_ignored rd_req got=%b want=0", req_after); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL finish_done_once got=%0d want=1", pulses); end
    total++; if (res !== model_result(base, 32)) begin bad++; $display("FAIL finish_result got=%h want=%h", res, model_result(base, 32)); end
  endtask

  task automatic test_abort();
    logic [31:0] res; int lat; int pulses; logic req_after; int base; int dcount; int rcount;
    dcount = 0; rcount = 0;
    foreach (mem[i]) mem[i] = 1'($urandom_range(0, 1));
    @(negedge clk);
    dataa = 32'($urandom_range(0, DEPTH - 1)); datab = 32'd32; start = 1'b1; rd_grant = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL abort_result got=%h want=0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL abort_rd_req got=%b want=0", rd_req); end
    total++; if (rdaddress !== '0) begin bad++; $display("FAIL abort_rdaddress got=%0d want=0", rdaddress); end
    repeat (50) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (rd_req) rcount++;
    end
    total++; if (dcount !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dcount); end
    total++; if (rcount !== 0) begin bad++; $display("FAIL abort_no_req got=%0d want=0", rcount); end
    base = $urandom_range(0, DEPTH - 1);
    do_read(base, 32'd20, 1'b1, 0, res, lat, pulses, req_after);
    total++; if (res !== model_result(base, 20)) begin bad++; $display("FAIL abort_recover got=%h want=%h", res, model_result(base, 20)); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_wrap();
    test_throttle();
    test_count_encoding();
    test_busy();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_pixel_reader.md
Name: fb_pixel_reader

Overview:
- Custom-instruction slave that reads pixels back from the 64x64 1-bit frame RAM (4096 addresses) to the processor.
- It is the read-side counterpart of the custom-instruction pixel writer.
- It takes a base address and pixel count, and fetches up to 32 consecutive pixels over an arbitrated RAM read port.
- It packs the pixels into `result` and pulses `done`.
- It shares the frame RAM read path with the VGA scan through a `rd_req`/`rd_grant` handshake.

Parameters:
- `ADDR_W`, 12, frame RAM address width; addresses wrap modulo 2^ADDR_W.
- `MAX_PIX`, 32, maximum pixels per instruction; equals the `result` width.
- `RAM_LAT`, 1, RAM read latency in cycles, from `rdaddress` sampled to `q` valid.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  custom-instruction start; one-cycle pulse.
- `dataa`  in  32  base pixel address; bits [ADDR_W-1:0] used, the rest ignored.
- `datab`  in  32  pixel count; bits [5:0] used; 0 or >32 is treated as 32.
- `result`  out  32  packed pixels; pixel k at bit k; unused upper bits are 0.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `rd_req`  out  1  request for the frame RAM read port.
- `rd_grant`  in  1  read port granted for this cycle; the arbiter drives it.
- `rdaddress`  out  ADDR_W  frame RAM read address.
- `q`  in  1  frame RAM read data.

Behaviour:
- Reset, applied while `reset`=0 at a `clk` edge:
  - state goes to IDLE;
  - `result`=0, `done`=0, `rd_req`=0, `rdaddress`=0;
  - issue/capture counters and the latency pipe are cleared.
  - Reset mid-operation aborts the transfer: no `done`, and in-flight RAM data is discarded.
- States: IDLE, REQ, BURST, DRAIN, FINISH.
- IDLE:
  - On `start`=1, latch base=`dataa[ADDR_W-1:0]` and N=count per the `datab` rule.
  - Clear the `result` shadow register, set `rd_req`=1, go to REQ.
  - `result` keeps its previous value until FINISH.
- REQ / BURST:
  - In each cycle with `rd_grant`=1, drive `rdaddress`=base+i (mod 2^ADDR_W) and increment the issue index i.
  - A valid bit enters a RAM_LAT-deep pipe tagged with index i.
  - Cycles with `rd_grant`=0 issue nothing: `rdaddress` holds and the pipe entry is invalid.
  - Grant may toggle arbitrarily; the burst pauses and resumes without loss or duplication.
- Capture: when a valid pipe entry emerges, `q` is written to shadow bit [tag].
- After issuing N addresses: drop `rd_req` in the next cycle and go to DRAIN.
- DRAIN: wait until all in-flight entries are captured, then go to FINISH.
- FINISH (one cycle):
  - `result` <= shadow, `done`=1, return to IDLE.
  - `done`=0 in every other state.
- Latency with `rd_grant` held at 1:
  - `start` sampled at edge T; `rd_req` is high from T+1; addresses are issued at T+1..T+N.
  - `done` is asserted in cycle T+N+RAM_LAT+1.
  - For N=32 and RAM_LAT=1, `done` is at T+34.
- `start` while not IDLE: ignored; no restart and no queuing.
- `start` in the same cycle as FINISH: ignored; the next `start` is accepted from IDLE.
- Address wrap: base=4090 with N=10 reads 4090..4095, then 0..3.
- `rd_req` stays high from REQ through the last issue, regardless of grant.
- `rdaddress` is don't-care to the RAM when `rd_grant`=0.
- Bits ≥N of `result` are 0.

Test Plan:
- Reset and idle: hold `reset`=0 for 3 cycles, then release.
  - Required: `result`=0, `done`=0, `rd_req`=0, `rdaddress`=0.
  - Required: no `done` for 50 cycles without `start`.
- Full burst, grant held at 1: RAM holds addr[k]=k[0]; `start` with `dataa`=0, `datab`=32.
  - Required: `result`=0xAAAAAAAA.
  - Required: `done` exactly 34 cycles after `start`, one cycle wide.
- Partial count with wrap: RAM bits are 1 at 4094, 4095, 0 and 0 elsewhere; `dataa`=4093, `datab`=5.
  - Required: `result`=0x0000000E.
  - Required: `rdaddress` sequence 4093, 4094, 4095, 0, 1.
- Grant throttling: `rd_grant` toggled 1,0,0,1,... in a pseudo-random pattern during a 32-pixel read of a known pattern.
  - Required: `result` equals the full-grant result.
  - Required: each address is issued exactly once.
- Count encoding: `datab`=0 reads 32 pixels; `datab`=45 reads 32 pixels; `datab`=1 sets only `result`[0].
- Busy and abort cases:
  - A second `start` mid-burst is ignored, and `done` is pulsed once.
  - Asserting `reset`=0 mid-burst yields no `done`, and all outputs return to reset values.
